mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 20, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, 16, SRAM data width.
REQ-003 SHALL have parameter WAIT_CYCLES, 2, strobe-active cycles per access (legal 1..15).
REQ-004 SHALL have port Clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port Reset  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports cpu_req/dma_req  in  1  access request, held until matching ack.
REQ-007 SHALL have ports cpu_we/dma_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports cpu_addr/dma_addr  in  ADDR_W  word address.
REQ-009 SHALL have ports cpu_wdata/dma_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports cpu_ack/dma_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports cpu_rdata/dma_rdata  out  DATA_W  read data, held until that requester's next read completes.
REQ-012 SHALL have ports Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  out  1 each  SRAM strobes, active-low.
REQ-013 SHALL have ports sram_addr  out  ADDR_W; sram_dq_out  out  DATA_W; sram_dq_oe  out  1  data-bus drive enable; sram_dq_in  in  DATA_W.
REQ-014 SHALL have ports busy  out  1  state != IDLE; owner  out  1  0 = CPU, 1 = DMA, current or last grantee.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 In IDLE with any req high, SHALL pick a winner, latch its we/addr/wdata, set owner, load wait counter to WAIT_CYCLES-1, and go to ACCESS.
REQ-017 In IDLE with no req, SHALL stay in IDLE with all strobes high.
REQ-018 In ACCESS, SHALL drive Mem_CE=0 and sram_addr=latched address.
REQ-019 In ACCESS for a read, SHALL drive Mem_OE=0.
REQ-020 In ACCESS for a write, SHALL drive Mem_WE=0, sram_dq_oe=1, sram_dq_out=latched wdata.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles, decrementing the counter; at counter 0 a read SHALL capture sram_dq_in into the owner's rdata register, then go to DONE.
REQ-022 In DONE, SHALL pulse the owner's ack for exactly one cycle with all strobes high and sram_dq_oe=0, then return to IDLE.
REQ-023 Latency: req sampled in IDLE at cycle 0 -> ack in cycle WAIT_CYCLES+1; back-to-back accesses every WAIT_CYCLES+2 cycles.
REQ-024 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-025 Requests SHALL NOT be abortable: if req drops during ACCESS, the access completes and ack still pulses.
REQ-026 Both acks SHALL never be high in the same cycle.
REQ-027 sram_dq_oe and Mem_OE=0 SHALL never coincide.
REQ-028 Mem_UB and Mem_LB SHALL be 0 whenever Mem_CE=0, else 1.
REQ-029 Counter width SHALL be 4 bits; WAIT_CYCLES=1 SHALL give a single ACCESS cycle.

Reset
REQ-030 Reset SHALL immediately, without waiting for a clock edge, force state=IDLE, all strobes=1, sram_dq_oe=0, acks=0, busy=0, owner=0, rdata=0, sram_addr=0, sram_dq_out=0, and last-grant=DMA.
REQ-031 An access interrupted by reset SHALL be dropped with no ack; requesters re-issue it.

Configuration
REQ-032 With MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last (round-robin; the first tie after reset goes to CPU).
REQ-033 Without MEM_ARB_RR_EN, the CPU SHALL always win ties (fixed priority; DMA may starve); the last-grant register SHALL be absent.

Structure
REQ-034 A package lc3_mem_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), the requester-ID constants (REQ_CPU=0, REQ_DMA=1), and the default wait-cycle constant.
REQ-035 A sub-module mem_arb_select SHALL contain the combinational winner selection, including the macro-dependent policy.

Verification
REQ-036 CPU read, WAIT_CYCLES=2, cpu_addr=0x00010, sram_dq_in=0xBEEF -> Mem_OE=0 in cycles 1-2, cpu_ack in cycle 3, cpu_rdata=0xBEEF.
REQ-037 DMA write 0x1234 to 0x00200 -> Mem_WE=0 and sram_dq_oe=1 in cycles 1-2, sram_dq_out=0x1234, dma_ack in cycle 3, cpu_ack stays 0.
REQ-038 Both req held high for 4 grants -> owner sequence CPU,DMA,CPU,DMA with MEM_ARB_RR_EN; CPU,CPU,CPU,CPU without it.
REQ-039 Reset asserted mid-cycle in the 1st ACCESS cycle of a write -> Mem_WE=1 and sram_dq_oe=0 before the next edge; no ack; state IDLE.
REQ-040 cpu_req dropped in the 1st ACCESS cycle -> access completes, cpu_ack pulses in cycle 3, no second access.
REQ-041 cpu_req held high through two reads -> acks in cycles 3 and 7, with busy=0 only in cycle 4.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: FSM states, requester IDs and default wait count shared by mem_arbiter.
package lc3_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
    localparam int DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: CPU/DMA winner selection; fixed CPU priority, or round-robin on ties
// when MEM_ARB_RR_EN is defined.
module mem_arb_select
    import lc3_mem_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic valid,
    output logic grant
);
    assign valid = cpu_req | dma_req;
`ifdef MEM_ARB_RR_EN
    assign grant = dma_req && (!cpu_req || last_grant == REQ_CPU);
`else
    assign grant = dma_req && !cpu_req;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates CPU and DMA access to an async SRAM with a fixed strobe width.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              busy,
    output logic              owner
);
    state_t     state;
    logic [3:0] cnt;
    logic       grant_valid;
    logic       grant;
    logic       sel_we;
`ifdef MEM_ARB_RR_EN
    logic       last_grant;
`endif

    mem_arb_select u_sel (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .valid      (grant_valid),
        .grant      (grant)
    );

    assign sel_we = grant ? dma_we : cpu_we;
    assign busy   = state != IDLE;
    assign Mem_UB = Mem_CE;
    assign Mem_LB = Mem_CE;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= REQ_CPU;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            Mem_CE      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant  <= REQ_DMA;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: if (grant_valid) begin
                    state       <= ACCESS;
                    owner       <= grant;
                    cnt         <= 4'(WAIT_CYCLES - 1);
                    sram_addr   <= grant ? dma_addr : cpu_addr;
                    sram_dq_out <= grant ? dma_wdata : cpu_wdata;
                    Mem_CE      <= 1'b0;
                    Mem_OE      <= sel_we;
                    Mem_WE      <= !sel_we;
                    sram_dq_oe  <= sel_we;
`ifdef MEM_ARB_RR_EN
                    last_grant  <= grant;
`endif
                end
                ACCESS: if (cnt == '0) begin
                    // Mem_OE low marks a read; sample the bus on the last strobe cycle
                    state      <= DONE;
                    Mem_CE     <= 1'b1;
                    Mem_OE     <= 1'b1;
                    Mem_WE     <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    cpu_ack    <= owner == REQ_CPU;
                    dma_ack    <= owner == REQ_DMA;
                    if (!Mem_OE && owner == REQ_CPU) cpu_rdata <= sram_dq_in;
                    if (!Mem_OE && owner == REQ_DMA) dma_rdata <= sram_dq_in;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
